// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core types and constants
package riscv_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [6:0] R_T    = 7'b0110011;
  localparam logic [6:0] I_T    = 7'b0010011;
  localparam logic [6:0] S_T    = 7'b0100011;
  localparam logic [6:0] B_T    = 7'b1100011;
  localparam logic [6:0] U_T    = 7'b0110111;
  localparam logic [6:0] J_T    = 7'b1101111;
  localparam logic [6:0] LW_T   = 7'b0000011;
  localparam logic [6:0] JALR_T = 7'b1100111;

  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_ALU = 2'b10;
  localparam logic [1:0] RES_PC4 = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jal;
    logic       jalr;
    logic       branch;
    logic [2:0] alu_op;
    logic [1:0] alu_src;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - load-use and redirect hazard detection
module hazard_detect
  import riscv_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rd_E,
  input  logic              reg_write_E,
  input  logic [1:0]        result_src_E,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic              pcsrc_E,
  output logic              stall_F,
  output logic              stall_D,
  output logic              flush_D,
  output logic              bubble
);

  logic ld_use;

  // rs2 is compared even when the D instruction has no rs2; a spurious stall is harmless.
  assign ld_use = reg_write_E && (result_src_E == RES_MEM) && (rd_E != '0)
                  && ((rd_E == rs1_D) || (rd_E == rs2_D));

  // A redirect wins over a load-use stall so the new PC is fetched immediately.
  assign stall_F = ld_use & ~pcsrc_E;
  assign stall_D = ld_use & ~pcsrc_E;
  assign flush_D = pcsrc_E;
  assign bubble  = ld_use | pcsrc_E;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with hazard control; PERF_CNT_EN adds bubble/stall counters
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write_D,
  input  logic [1:0]        result_src_D,
  input  logic              mem_write_D,
  input  logic              jal_D,
  input  logic              jalr_D,
  input  logic              branch_D,
  input  logic [2:0]        alu_op_D,
  input  logic [1:0]        alu_src_D,
  input  logic [2:0]        funct3_D,
  input  logic [XLEN-1:0]   rd1_D,
  input  logic [XLEN-1:0]   rd2_D,
  input  logic [XLEN-1:0]   imm_D,
  input  logic [XLEN-1:0]   pc_D,
  input  logic [XLEN-1:0]   pc_plus4_D,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic [REG_AW-1:0] rd_D,
  input  logic              pcsrc_E,
  output logic              reg_write_E,
  output logic [1:0]        result_src_E,
  output logic              mem_write_E,
  output logic              jal_E,
  output logic              jalr_E,
  output logic              branch_E,
  output logic [2:0]        alu_op_E,
  output logic [1:0]        alu_src_E,
  output logic [2:0]        funct3_E,
  output logic [XLEN-1:0]   rd1_E,
  output logic [XLEN-1:0]   rd2_E,
  output logic [XLEN-1:0]   imm_E,
  output logic [XLEN-1:0]   pc_E,
  output logic [XLEN-1:0]   pc_plus4_E,
  output logic [REG_AW-1:0] rs1_E,
  output logic [REG_AW-1:0] rs2_E,
  output logic [REG_AW-1:0] rd_E,
  output logic              stall_F,
  output logic              stall_D,
`ifdef PERF_CNT_EN
  output logic              flush_D,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  lu_stall_cnt
`else
  output logic              flush_D
`endif
);

  ctrl_t             ctrl_d, ctrl_q;
  logic [2:0]        funct3_d, funct3_q;
  logic [XLEN-1:0]   rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
  logic [XLEN-1:0]   pc_d, pc_q, pc_plus4_d, pc_plus4_q;
  logic [REG_AW-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic              bubble;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .rd_E         (rd_q),
    .reg_write_E  (ctrl_q.reg_write),
    .result_src_E (ctrl_q.result_src),
    .rs1_D        (rs1_D),
    .rs2_D        (rs2_D),
    .pcsrc_E      (pcsrc_E),
    .stall_F      (stall_F),
    .stall_D      (stall_D),
    .flush_D      (flush_D),
    .bubble       (bubble)
  );

  always_comb begin
    ctrl_d     = '{reg_write: reg_write_D, result_src: result_src_D, mem_write: mem_write_D,
                   jal: jal_D, jalr: jalr_D, branch: branch_D, alu_op: alu_op_D, alu_src: alu_src_D};
    funct3_d   = funct3_D;
    rd1_d      = rd1_D;
    rd2_d      = rd2_D;
    imm_d      = imm_D;
    pc_d       = pc_D;
    pc_plus4_d = pc_plus4_D;
    rs1_d      = rs1_D;
    rs2_d      = rs2_D;
    rd_d       = rd_D;
    // A bubble is a fully zeroed EX slot, data included, so nothing stale leaks forward.
    if (bubble) begin
      ctrl_d     = '0;
      funct3_d   = '0;
      rd1_d      = '0;
      rd2_d      = '0;
      imm_d      = '0;
      pc_d       = '0;
      pc_plus4_d = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      funct3_q   <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      funct3_q   <= funct3_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
    end
  end

  assign reg_write_E  = ctrl_q.reg_write;
  assign result_src_E = ctrl_q.result_src;
  assign mem_write_E  = ctrl_q.mem_write;
  assign jal_E        = ctrl_q.jal;
  assign jalr_E       = ctrl_q.jalr;
  assign branch_E     = ctrl_q.branch;
  assign alu_op_E     = ctrl_q.alu_op;
  assign alu_src_E    = ctrl_q.alu_src;
  assign funct3_E     = funct3_q;
  assign rd1_E        = rd1_q;
  assign rd2_E        = rd2_q;
  assign imm_E        = imm_q;
  assign pc_E         = pc_q;
  assign pc_plus4_E   = pc_plus4_q;
  assign rs1_E        = rs1_q;
  assign rs2_E        = rs2_q;
  assign rd_E         = rd_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q, lu_stall_cnt_d, lu_stall_cnt_q;

  // Counters wrap naturally at 2^CNT_W.
  always_comb begin
    bubble_cnt_d   = bubble_cnt_q + (bubble ? CNT_W'(1) : CNT_W'(0));
    lu_stall_cnt_d = lu_stall_cnt_q + (stall_D ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q   <= '0;
      lu_stall_cnt_q <= '0;
    end else begin
      bubble_cnt_q   <= bubble_cnt_d;
      lu_stall_cnt_q <= lu_stall_cnt_d;
    end
  end

  assign bubble_cnt   = bubble_cnt_q;
  assign lu_stall_cnt = lu_stall_cnt_q;
`else
  // Counter width is meaningful only when the counters are built.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage (table, directed and random vs reference model)
module tb_id_ex_stage;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jal;
    logic        jalr;
    logic        branch;
    logic [2:0]  alu_op;
    logic [1:0]  alu_src;
    logic [2:0]  funct3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } stage_t;

  typedef struct {
    logic       prev_rw;
    logic [1:0] prev_rs;
    logic [4:0] prev_rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       pcsrc;
    logic       exp_stall;
    logic       exp_flush;
    logic       exp_bubble;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   pcsrc_E = 1'b0;
  stage_t d = '0;
  stage_t e_act;
  logic   stall_F, stall_D, flush_D;

  logic        reg_write_E, mem_write_E, jal_E, jalr_E, branch_E;
  logic [1:0]  result_src_E, alu_src_E;
  logic [2:0]  alu_op_E, funct3_E;
  logic [31:0] rd1_E, rd2_E, imm_E, pc_E, pc_plus4_E;
  logic [4:0]  rs1_E, rs2_E, rd_E;
`ifdef PERF_CNT_EN
  logic [15:0] bubble_cnt, lu_stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state
  stage_t exp_e = '0;
  logic   model_valid = 1'b0;
  int     exp_bub_cnt = 0;
  int     exp_lu_cnt = 0;
  logic   stall_s, flush_s;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .reg_write_D(d.reg_write), .result_src_D(d.result_src), .mem_write_D(d.mem_write),
    .jal_D(d.jal), .jalr_D(d.jalr), .branch_D(d.branch), .alu_op_D(d.alu_op),
    .alu_src_D(d.alu_src), .funct3_D(d.funct3), .rd1_D(d.rd1), .rd2_D(d.rd2),
    .imm_D(d.imm), .pc_D(d.pc), .pc_plus4_D(d.pc_plus4),
    .rs1_D(d.rs1), .rs2_D(d.rs2), .rd_D(d.rd), .pcsrc_E(pcsrc_E),
    .reg_write_E(reg_write_E), .result_src_E(result_src_E), .mem_write_E(mem_write_E),
    .jal_E(jal_E), .jalr_E(jalr_E), .branch_E(branch_E), .alu_op_E(alu_op_E),
    .alu_src_E(alu_src_E), .funct3_E(funct3_E), .rd1_E(rd1_E), .rd2_E(rd2_E),
    .imm_E(imm_E), .pc_E(pc_E), .pc_plus4_E(pc_plus4_E),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .stall_F(stall_F), .stall_D(stall_D),
`ifdef PERF_CNT_EN
    .flush_D(flush_D), .bubble_cnt(bubble_cnt), .lu_stall_cnt(lu_stall_cnt)
`else
    .flush_D(flush_D)
`endif
  );

  assign e_act = {reg_write_E, result_src_E, mem_write_E, jal_E, jalr_E, branch_E,
                  alu_op_E, alu_src_E, funct3_E, rd1_E, rd2_E, imm_E, pc_E, pc_plus4_E,
                  rs1_E, rs2_E, rd_E};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic stage_t rand_d();
    stage_t s;
    s.reg_write  = 1'($urandom_range(0, 1));
    s.result_src = 2'($urandom_range(0, 3));
    s.mem_write  = 1'($urandom_range(0, 1));
    s.jal        = 1'($urandom_range(0, 1));
    s.jalr       = 1'($urandom_range(0, 1));
    s.branch     = 1'($urandom_range(0, 1));
    s.alu_op     = 3'($urandom_range(0, 7));
    s.alu_src    = 2'($urandom_range(0, 3));
    s.funct3     = 3'($urandom_range(0, 7));
    s.rd1        = $urandom();
    s.rd2        = $urandom();
    s.imm        = $urandom();
    s.pc         = $urandom();
    s.pc_plus4   = s.pc + 32'd4;
    s.rs1        = 5'($urandom_range(0, 3));
    s.rs2        = 5'($urandom_range(0, 3));
    s.rd         = 5'($urandom_range(0, 3));
    return s;
  endfunction

  // One clock: drive, check hazard outputs, clock, check EX register against the model.
  task automatic cycle(input logic r, input stage_t dv, input logic p);
    logic ld;
    rst = r; d = dv; pcsrc_E = p;
    #1;
    ld = exp_e.reg_write && exp_e.result_src == 2'b01 && exp_e.rd != 0
         && (exp_e.rd == dv.rs1 || exp_e.rd == dv.rs2);
    stall_s = stall_F;
    flush_s = flush_D;
    if (model_valid) begin
      chk("stall_F", 256'(stall_F), 256'(ld && !p));
      chk("stall_D", 256'(stall_D), 256'(ld && !p));
      chk("flush_D", 256'(flush_D), 256'(p));
    end
    @(posedge clk);
    if (r) begin
      exp_e = '0; exp_bub_cnt = 0; exp_lu_cnt = 0;
    end else if (p || ld) begin
      exp_e = '0;
      exp_bub_cnt = (exp_bub_cnt + 1) % 65536;
      if (ld && !p) exp_lu_cnt = (exp_lu_cnt + 1) % 65536;
    end else begin
      exp_e = dv;
    end
    model_valid = model_valid | r;
    #1;
    if (model_valid) begin
      chk("ex_regs", 256'(e_act), 256'(exp_e));
`ifdef PERF_CNT_EN
      chk("bubble_cnt", 256'(bubble_cnt), 256'(exp_bub_cnt));
      chk("lu_stall_cnt", 256'(lu_stall_cnt), 256'(exp_lu_cnt));
`endif
    end
  endtask

  vec_t vecs[7];
  stage_t s, s2;

  initial begin
    // Reset with nonzero D inputs
    s = rand_d();
    s.reg_write = 1'b1; s.result_src = 2'b01; s.rd = 5'd3; s.rs1 = 5'd3;
    cycle(1'b1, s, 1'b0);
    cycle(1'b1, s, 1'b1);
    chk("reset_ex", 256'(e_act), 256'(0));
    rst = 1'b0; pcsrc_E = 1'b0; #1;
    chk("reset_haz", 256'({stall_F, stall_D, flush_D}), 256'(0));

    // Pass-through
    s = '0;
    s.reg_write = 1'b1; s.result_src = 2'b10; s.alu_op = 3'b010; s.rd1 = 32'h1234; s.rd = 5'd5;
    cycle(1'b0, s, 1'b0);
    chk("pass_through", 256'(e_act), 256'(s));

    // Hazard table: prev D goes into E, then cur D is presented
    vecs[0] = '{1'b1, 2'b01, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 2'b01, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 2'b01, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 2'b01, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 2'b10, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 2'b01, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 2'b00, 5'd0, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, rand_d(), 1'b0);
      s = rand_d();
      s.reg_write = vecs[i].prev_rw; s.result_src = vecs[i].prev_rs; s.rd = vecs[i].prev_rd;
      s.rs1 = 5'd9; s.rs2 = 5'd9;
      cycle(1'b0, s, 1'b0);
      s2 = rand_d();
      s2.rs1 = vecs[i].rs1; s2.rs2 = vecs[i].rs2;
      cycle(1'b0, s2, vecs[i].pcsrc);
      chk($sformatf("vec%0d_stall", i), 256'(stall_s), 256'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_flush", i), 256'(flush_s), 256'(vecs[i].exp_flush));
      chk($sformatf("vec%0d_ex", i), 256'(e_act), vecs[i].exp_bubble ? 256'(0) : 256'(s2));
    end

    // Load-use: one bubble, then the held D instruction enters E
    s = '0; s.reg_write = 1'b1; s.result_src = 2'b01; s.rd = 5'd7;
    cycle(1'b0, s, 1'b0);
    s2 = rand_d(); s2.rs1 = 5'd7; s2.rs2 = 5'd0;
    cycle(1'b0, s2, 1'b0);
    chk("lu_stall", 256'(stall_s), 256'(1));
    chk("lu_bubble", 256'(e_act), 256'(0));
    cycle(1'b0, s2, 1'b0);
    chk("lu_release", 256'(stall_s), 256'(0));
    chk("lu_follow", 256'(e_act), 256'(s2));

    // Reset mid-stall: stall drops once E is cleared
    s = '0; s.reg_write = 1'b1; s.result_src = 2'b01; s.rd = 5'd2;
    cycle(1'b0, s, 1'b0);
    s2 = rand_d(); s2.rs1 = 5'd2;
    cycle(1'b1, s2, 1'b0);
    chk("rst_mid_stall_was", 256'(stall_s), 256'(1));
    cycle(1'b0, s2, 1'b0);
    chk("rst_mid_stall_after", 256'(stall_s), 256'(0));

    // Randomized run against the model
    cycle(1'b1, rand_d(), 1'b0);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 39) == 0, rand_d(), $urandom_range(0, 5) == 0);

`ifdef PERF_CNT_EN
    // Three load-use events and two redirects
    cycle(1'b1, rand_d(), 1'b0);
    for (int i = 0; i < 3; i++) begin
      s = '0; s.reg_write = 1'b1; s.result_src = 2'b01; s.rd = 5'd4;
      cycle(1'b0, s, 1'b0);
      s2 = '0; s2.rs2 = 5'd4;
      cycle(1'b0, s2, 1'b0);
    end
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("lu_cnt_3", 256'(lu_stall_cnt), 256'(3));
    chk("bub_cnt_5", 256'(bubble_cnt), 256'(5));
    // Wrap: 65536 bubbles from reset brings the counter back to 0
    cycle(1'b1, '0, 1'b0);
    for (int i = 0; i < 65535; i++) cycle(1'b0, '0, 1'b1);
    chk("bub_cnt_ffff", 256'(bubble_cnt), 256'(16'hFFFF));
    cycle(1'b0, '0, 1'b1);
    chk("bub_cnt_wrap", 256'(bubble_cnt), 256'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
